// File: rtl/stepper_step_gen.sv
// Purpose : Avalon-MM controlled stepper-motor step/direction pulse generator.
// Latency : readdata is registered (1 clk after address); step rises 1 clk after an accepted tick.
// Backpr. : none; the slave always accepts writes, and ticks outside WAIT_TICK are dropped.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   address/chipselect/write_n     Avalon slave control (write = chipselect && !write_n)
//   writedata/readdata             16-bit register data (readdata updates every cycle)
//   tick                           one-cycle step-rate pulse
//   limit_n                        active-low limit switch (clk-synchronous)
//   step, dir                      motor driver outputs
//   irq                            level interrupt = done && irq_en
//
// Register map: 0 status {limit_hit, done, busy}, 1 control {stop, start, dir, irq_en},
//               2 step_count, 3 pulse_width, 4 steps_remaining (RO), 5-7 read 0.
//
// Build option: define STEPPER_LIMIT_STOP_EN to let limit_n abort moves and block starts.
module stepper_step_gen #(
  parameter logic [15:0] PULSE_WIDTH_RST = 16'd50,
  parameter logic [15:0] STEP_COUNT_RST  = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        tick,
  input  logic        limit_n,
  output logic        step,
  output logic        dir,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TICK = 2'd1;
  localparam logic [1:0] ST_PULSE     = 2'd2;

  logic [1:0]  state;
  logic        irq_en;
  logic        ctrl_dir;
  logic        done;
  logic        limit_hit;
  logic [15:0] step_count;
  logic [15:0] pulse_width;
  logic [15:0] steps_remaining;
  logic [15:0] width_cnt;

  logic        wr;
  logic        wr_status;
  logic        wr_ctrl;
  logic        start_strb;
  logic        stop_strb;
  logic        busy;
  logic        limit_active;
  logic        limit_stop;
  logic [15:0] width_load;
  logic [15:0] rd_mux;

  assign wr         = chipselect && !write_n;
  assign wr_status  = wr && (address == 3'd0);
  assign wr_ctrl    = wr && (address == 3'd1);
  assign start_strb = wr_ctrl && writedata[2];
  assign stop_strb  = wr_ctrl && writedata[3];
  assign busy       = (state != ST_IDLE);

  // A zero pulse width still produces a one-cycle pulse.
  assign width_load = (pulse_width == 16'd0) ? 16'd1 : pulse_width;

`ifdef STEPPER_LIMIT_STOP_EN
  assign limit_active = !limit_n;
`else
  logic unused_limit_n;
  assign unused_limit_n = limit_n;
  assign limit_active   = 1'b0;
`endif

  // The limit switch only aborts a move in progress; in IDLE it blocks start instead.
  assign limit_stop = limit_active && busy;

  assign irq = done && irq_en;

  always_comb begin
    rd_mux = 16'd0;
    case (address)
      3'd0:    rd_mux = {13'd0, limit_hit, done, busy};
      3'd1:    rd_mux = {14'd0, ctrl_dir, irq_en};
      3'd2:    rd_mux = step_count;
      3'd3:    rd_mux = pulse_width;
      3'd4:    rd_mux = steps_remaining;
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      step            <= 1'b0;
      dir             <= 1'b0;
      readdata        <= 16'd0;
      irq_en          <= 1'b0;
      ctrl_dir        <= 1'b0;
      done            <= 1'b0;
      limit_hit       <= 1'b0;
      steps_remaining <= 16'd0;
      width_cnt       <= 16'd0;
      pulse_width     <= PULSE_WIDTH_RST;
      step_count      <= STEP_COUNT_RST;
    end else begin
      readdata <= rd_mux;

      if (wr_ctrl) begin
        irq_en   <= writedata[0];
        ctrl_dir <= writedata[1];
      end
      if (wr && (address == 3'd2)) step_count  <= writedata;
      if (wr && (address == 3'd3)) pulse_width <= writedata;

      // Status write clears the sticky flags; a flag set by the FSM in the
      // same cycle (assigned later below) wins so no completion is lost.
      if (wr_status) begin
        done      <= 1'b0;
        limit_hit <= 1'b0;
      end

      if (stop_strb || limit_stop) begin
        // Abort: steps_remaining is deliberately left as-is.
        state <= ST_IDLE;
        step  <= 1'b0;
        done  <= 1'b1;
        if (limit_stop) limit_hit <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_strb) begin
              if (limit_active) begin
                done      <= 1'b1;
                limit_hit <= 1'b1;
              end else begin
                steps_remaining <= step_count;
                if (step_count == 16'd0) begin
                  done <= 1'b1;
                end else begin
                  // Direction comes from the same control write that carries start.
                  dir   <= writedata[1];
                  state <= ST_WAIT_TICK;
                end
              end
            end
          end
          ST_WAIT_TICK: begin
            if (tick) begin
              step      <= 1'b1;
              width_cnt <= width_load;
              state     <= ST_PULSE;
            end
          end
          ST_PULSE: begin
            if (width_cnt <= 16'd1) begin
              step            <= 1'b0;
              steps_remaining <= steps_remaining - 16'd1;
              if (steps_remaining == 16'd1) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                state <= ST_WAIT_TICK;
              end
            end else begin
              width_cnt <= width_cnt - 16'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            step  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stepper_step_gen.sv
module tb_stepper_step_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        tick = 1'b0;
  logic        limit_n = 1'b1;
  logic        step;
  logic        dir;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  stepper_step_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .tick       (tick),
    .limit_n    (limit_n),
    .step       (step),
    .dir        (dir),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wr, input logic [2:0] a, input logic [15:0] d,
                         input logic [15:0] e, input string name);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Reads leave chipselect low: readdata must follow address regardless.
  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // Drives tick on cycles where c % period == phase, and measures step pulses.
  task automatic run_ticks(input int cycles, input int period, input int phase,
                           output int pulses, output int wmin, output int wmax,
                           output int gmin, output logic last_step);
    int cur;
    int gap;
    bit seen;
    pulses = 0; wmin = 1 << 30; wmax = 0; gmin = 1 << 30;
    cur = 0; gap = 0; seen = 1'b0; last_step = 1'b0;
    for (int c = 0; c <= cycles; c++) begin
      @(negedge clk);
      if (step) begin
        if (cur == 0 && seen && gap < gmin) gmin = gap;
        cur++;
        gap = 0;
      end else begin
        if (cur > 0) begin
          pulses++;
          seen = 1'b1;
          if (cur < wmin) wmin = cur;
          if (cur > wmax) wmax = cur;
          cur = 0;
        end
        gap++;
      end
      last_step = step;
      tick = (c < cycles) && (c % period == phase);
    end
    tick = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    int p, wmin, wmax, gmin, p2;
    logic ls;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_step", 16'(step), 16'd0);
    check("rst_dir", 16'(dir), 16'd0);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_readdata", readdata, 16'd0);
    reset_n = 1'b1;

    // Register map vectors
    add_vec(1'b0, 3'd0, 16'h0000, 16'h0000, "rd_status_rst");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0000, "rd_ctrl_rst");
    add_vec(1'b0, 3'd2, 16'h0000, 16'h0000, "rd_step_count_rst");
    add_vec(1'b0, 3'd3, 16'h0000, 16'd50,   "rd_pulse_width_rst");
    add_vec(1'b0, 3'd4, 16'h0000, 16'h0000, "rd_remaining_rst");
    add_vec(1'b0, 3'd5, 16'h0000, 16'h0000, "rd_addr5");
    add_vec(1'b0, 3'd6, 16'h0000, 16'h0000, "rd_addr6");
    add_vec(1'b0, 3'd7, 16'h0000, 16'h0000, "rd_addr7");
    add_vec(1'b1, 3'd2, 16'h1234, 16'h0000, "");
    add_vec(1'b0, 3'd2, 16'h0000, 16'h1234, "rd_step_count_wr");
    add_vec(1'b1, 3'd3, 16'h00ff, 16'h0000, "");
    add_vec(1'b0, 3'd3, 16'h0000, 16'h00ff, "rd_pulse_width_wr");
    add_vec(1'b1, 3'd1, 16'h0003, 16'h0000, "");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0003, "rd_ctrl_3");
    add_vec(1'b1, 3'd1, 16'h0002, 16'h0000, "");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0002, "rd_ctrl_2");
    add_vec(1'b1, 3'd1, 16'h0000, 16'h0000, "");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0000, "rd_ctrl_0");
    add_vec(1'b1, 3'd5, 16'hffff, 16'h0000, "");
    add_vec(1'b0, 3'd5, 16'h0000, 16'h0000, "rd_addr5_after_wr");
    add_vec(1'b0, 3'd0, 16'h0000, 16'h0000, "rd_status_idle");

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end

    // Three 4-cycle pulses; mid-move start/dir/step_count writes must not disturb it
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd3);
    bus_write(3'd3, 16'd4);
    bus_write(3'd1, 16'h0006);
    check("a_dir_sampled", 16'(dir), 16'd1);
    bus_read(3'd0, rd);
    check("a_busy", rd, 16'h0001);
    run_ticks(40, 20, 5, p, wmin, wmax, gmin, ls);
    check("a_pulses_1", 16'(p), 16'd2);
    check("a_wmin_1", 16'(wmin), 16'd4);
    check("a_wmax_1", 16'(wmax), 16'd4);
    bus_read(3'd4, rd);
    check("a_remaining_mid", rd, 16'd1);
    bus_write(3'd2, 16'd7);
    bus_write(3'd1, 16'h0004);
    check("a_dir_held", 16'(dir), 16'd1);
    run_ticks(60, 20, 5, p, wmin, wmax, gmin, ls);
    check("a_pulses_2", 16'(p), 16'd1);
    check("a_wmax_2", 16'(wmax), 16'd4);
    bus_read(3'd0, rd);
    check("a_status_done", rd, 16'h0002);
    bus_read(3'd4, rd);
    check("a_remaining_end", rd, 16'd0);

    // Stop and start in the same write: stop wins
    bus_write(3'd0, 16'h0000);
    bus_write(3'd1, 16'h000C);
    bus_read(3'd0, rd);
    check("ss_status", rd, 16'h0002);
    run_ticks(10, 2, 0, p, wmin, wmax, gmin, ls);
    check("ss_no_pulses", 16'(p), 16'd0);

    // step_count = 0: immediate done, never busy
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd0);
    bus_write(3'd1, 16'h0004);
    bus_read(3'd0, rd);
    check("z_status", rd, 16'h0002);
    run_ticks(10, 2, 1, p, wmin, wmax, gmin, ls);
    check("z_no_pulses", 16'(p), 16'd0);
    bus_read(3'd0, rd);
    check("z_status_later", rd, 16'h0002);

    // Stop during the second pulse of a 10-step move
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd10);
    bus_write(3'd3, 16'd4);
    bus_write(3'd1, 16'h0004);
    run_ticks(27, 20, 5, p, wmin, wmax, gmin, ls);
    check("c_pulses_before", 16'(p), 16'd1);
    check("c_step_high", 16'(ls), 16'd1);
    bus_write(3'd1, 16'h0008);
    check("c_step_dropped", 16'(step), 16'd0);
    bus_read(3'd0, rd);
    check("c_status", rd, 16'h0002);
    bus_read(3'd4, rd);
    check("c_remaining", rd, 16'd9);

    // irq on completion, cleared by a status write
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd1);
    bus_write(3'd3, 16'd2);
    bus_write(3'd1, 16'h0005);
    check("d_irq_low_busy", 16'(irq), 16'd0);
    bus_read(3'd1, rd);
    check("d_ctrl_no_start", rd, 16'h0001);
    run_ticks(20, 20, 5, p, wmin, wmax, gmin, ls);
    check("d_pulses", 16'(p), 16'd1);
    check("d_width", 16'(wmax), 16'd2);
    check("d_irq_high", 16'(irq), 16'd1);
    bus_write(3'd0, 16'h0000);
    check("d_irq_cleared", 16'(irq), 16'd0);

    // Tick every cycle with pulse_width = 0
    bus_write(3'd1, 16'h0000);
    bus_write(3'd2, 16'd4);
    bus_write(3'd3, 16'd0);
    bus_write(3'd1, 16'h0004);
    run_ticks(20, 1, 0, p, wmin, wmax, gmin, ls);
    check("e_pulses", 16'(p), 16'd4);
    check("e_wmin", 16'(wmin), 16'd1);
    check("e_wmax", 16'(wmax), 16'd1);
    check("e_gap", 16'(gmin), 16'd1);
    bus_read(3'd0, rd);
    check("e_status", rd, 16'h0002);
    bus_read(3'd4, rd);
    check("e_remaining", rd, 16'd0);

    // Limit switch low mid-move
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd5);
    bus_write(3'd3, 16'd3);
    bus_write(3'd1, 16'h0004);
    run_ticks(29, 10, 2, p, wmin, wmax, gmin, ls);
    check("f_pulses_before", 16'(p), 16'd3);
    limit_n = 1'b0;
    run_ticks(60, 10, 2, p2, wmin, wmax, gmin, ls);
    limit_n = 1'b1;
`ifdef STEPPER_LIMIT_STOP_EN
    check("f_pulses_after", 16'(p2), 16'd0);
    bus_read(3'd0, rd);
    check("f_status", rd, 16'h0006);
    bus_read(3'd4, rd);
    check("f_remaining", rd, 16'd2);
    bus_write(3'd0, 16'h0000);
    limit_n = 1'b0;
    bus_write(3'd1, 16'h0004);
    limit_n = 1'b1;
    bus_read(3'd0, rd);
    check("f_start_blocked", rd, 16'h0006);
`else
    check("f_pulses_after", 16'(p2), 16'd2);
    bus_read(3'd0, rd);
    check("f_status", rd, 16'h0002);
    bus_read(3'd4, rd);
    check("f_remaining", rd, 16'd0);
`endif

    // Asynchronous reset mid-pulse
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd2);
    bus_write(3'd3, 16'd10);
    bus_write(3'd1, 16'h0004);
    run_ticks(8, 20, 3, p, wmin, wmax, gmin, ls);
    check("r_step_high", 16'(ls), 16'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("r_step_async_drop", 16'(step), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd0, rd);
    check("r_status", rd, 16'h0000);
    bus_read(3'd3, rd);
    check("r_pulse_width", rd, 16'd50);
    bus_read(3'd4, rd);
    check("r_remaining", rd, 16'd0);
    check("r_irq", 16'(irq), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
